// File: rtl/debug_reg_dumper.sv
// Snapshots the register-file debug bus on request and streams it out one byte
// per valid/ready transfer, register 0 first, least-significant byte first.
module debug_reg_dumper #(
  parameter int unsigned PROC_BITS = 32,
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned BYTE_BITS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_start,
  input  logic [PROC_BITS*NUM_REGS-1:0] i_debug_regs,
  output logic [BYTE_BITS-1:0]          o_tx_data,
  output logic                          o_tx_valid,
  input  logic                          i_tx_ready,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam int unsigned N_BYTES = (NUM_REGS * PROC_BITS) / BYTE_BITS;
  localparam int unsigned IDX_W   = $clog2(N_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                             r_state;
  logic [IDX_W-1:0]                   r_index;
  logic [N_BYTES-1:0][BYTE_BITS-1:0]  r_snapshot;
  logic [BYTE_BITS-1:0]               r_tx_data;
  logic                               r_tx_valid;
  logic                               r_busy;
  logic                               r_done;

  state_t                             w_state_nxt;
  logic [IDX_W-1:0]                   w_index_nxt;
  logic                               w_load;
  logic [BYTE_BITS-1:0]               w_data_nxt;
  logic                               w_valid_nxt;
  logic                               w_busy_nxt;
  logic                               w_done_nxt;

  // State, index and snapshot registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_index    <= '0;
      r_snapshot <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_index <= w_index_nxt;
      if (w_load) r_snapshot <= i_debug_regs;
    end
  end

  // Next state plus next output values; outputs are registered so the
  // handshake inputs never reach a port combinationally
  always_comb begin
    w_state_nxt = r_state;
    w_index_nxt = r_index;
    w_load      = 1'b0;
    w_data_nxt  = '0;
    w_valid_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_SEND;
          w_index_nxt = '0;
          w_load      = 1'b1;
          w_valid_nxt = 1'b1;
          w_data_nxt  = i_debug_regs[BYTE_BITS-1:0];
        end
      end
      S_SEND: begin
        if (i_tx_ready && (r_index == LAST_IDX)) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          if (i_tx_ready) w_index_nxt = r_index + IDX_W'(1);
          w_valid_nxt = 1'b1;
          w_data_nxt  = r_snapshot[w_index_nxt];
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_index_nxt = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_index_nxt = '0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // Output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_tx_data  <= w_data_nxt;
      r_tx_valid <= w_valid_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign o_tx_data  = r_tx_data;
  assign o_tx_valid = r_tx_valid;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: tb/tb_debug_reg_dumper.sv
// Randomized bench for debug_reg_dumper: a register-array model predicts the
// byte stream, handshake stability and done/busy timing.
module tb_debug_reg_dumper;

  localparam int NREG = 32;
  localparam int NB   = NREG * 4;

  logic              clk;
  logic              rst;
  logic              i_start;
  logic [NREG*32-1:0] dbg_bus;
  logic [7:0]        o_tx_data;
  logic              o_tx_valid;
  logic              i_tx_ready;
  logic              o_busy;
  logic              o_done;

  logic [31:0] regs [NREG];
  int n_checks = 0;
  int n_errors = 0;

  debug_reg_dumper dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_debug_regs(dbg_bus),
    .o_tx_data   (o_tx_data),
    .o_tx_valid  (o_tx_valid),
    .i_tx_ready  (i_tx_ready),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_regs();
    for (int k = 0; k < NREG; k++) dbg_bus[k*32 +: 32] = regs[k];
  endtask

  task automatic basic_regs();
    for (int k = 0; k < NREG; k++) regs[k] = 32'h0;
    regs[0]  = 32'd17;
    regs[1]  = 32'd3;
    regs[31] = 32'hDEADBEEF;
    push_regs();
  endtask

  task automatic random_regs();
    for (int k = 0; k < NREG; k++) regs[k] = $urandom;
    push_regs();
  endtask

  task automatic kick();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(o_tx_valid), 32'd0);
    check({tag, "_busy"},  32'(o_busy),     32'd0);
    check({tag, "_done"},  32'(o_done),     32'd0);
  endtask

  // Called at the first negedge after i_start was sampled.
  // mode: 0 ready always, 1 ready pattern 1,0,0,1, 2 random ready.
  task automatic drain(input int mode, input bit iso, input bit restart,
                       input int rst_at, input bit hold);
    logic [31:0] snap [NREG];
    logic [7:0]  q[$];
    logic [7:0]  pdata;
    logic [7:0]  exp_b;
    bit   stalled, fin, rdy;
    int   vcyc, acc, ndone;
    for (int k = 0; k < NREG; k++) snap[k] = regs[k];
    stalled = 1'b0; fin = 1'b0; vcyc = 0; acc = 0; ndone = 0; pdata = '0;
    for (int cyc = 0; cyc < 1500 && !fin; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (i_start && !hold) i_start = 1'b0;
      if (stalled) begin
        check("stall_valid", 32'(o_tx_valid), 32'd1);
        check("stall_data",  32'(o_tx_data),  32'(pdata));
      end
      if (o_done) begin
        ndone++;
        check("done_valid", 32'(o_tx_valid), 32'd0);
        check("done_busy",  32'(o_busy),     32'd1);
        fin = 1'b1;
      end else begin
        check("send_valid", 32'(o_tx_valid), 32'd1);
        check("send_busy",  32'(o_busy),     32'd1);
      end
      if (o_tx_valid) vcyc++;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      i_tx_ready = rdy;
      stalled = o_tx_valid && !rdy;
      pdata   = o_tx_data;
      if (o_tx_valid && rdy) begin
        q.push_back(o_tx_data);
        acc++;
        if (iso && acc == 2) begin
          regs[1] = 32'd144;
          regs[0] = $urandom;
          push_regs();
        end
        if (restart && acc == 50) i_start = 1'b1;
        if (rst_at != 0 && acc == rst_at) begin
          rst = 1'b0;
          #1;
          check("arst_valid", 32'(o_tx_valid), 32'd0);
          check("arst_busy",  32'(o_busy),     32'd0);
          check("arst_done",  32'(o_done),     32'd0);
          check("arst_data",  32'(o_tx_data),  32'd0);
          repeat (3) @(negedge clk);
          i_start = 1'b0;
          rst = 1'b1;
          for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check_idle("post_arst");
          end
          return;
        end
      end
    end
    if (!fin) begin
      check("timeout", 32'd0, 32'd1);
      return;
    end
    check("byte_count", 32'(q.size()), 32'(NB));
    check("done_count", 32'(ndone), 32'd1);
    if (mode == 0) check("valid_cycles", 32'(vcyc), 32'(NB));
    for (int i = 0; i < q.size() && i < NB; i++) begin
      exp_b = 8'(snap[i / 4] >> (8 * (i % 4)));
      check($sformatf("byte%0d", i), 32'(q[i]), 32'(exp_b));
    end
    @(negedge clk);
    check_idle("after_done");
  endtask

  initial begin
    rst = 1'b0;
    i_start = 1'b1;
    i_tx_ready = 1'b1;
    basic_regs();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_idle("in_reset");
      check("in_reset_data", 32'(o_tx_data), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("first_edge_valid", 32'(o_tx_valid), 32'd1);
    check("first_edge_data",  32'(o_tx_data),  32'h11);
    i_start = 1'b0;
    drain(0, 1'b0, 1'b0, 0, 1'b0);

    kick();
    drain(1, 1'b0, 1'b0, 0, 1'b0);

    basic_regs();
    kick();
    drain(0, 1'b1, 1'b0, 0, 1'b0);

    random_regs();
    kick();
    drain(2, 1'b0, 1'b1, 0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_idle("no_queued_start");
    end

    random_regs();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    drain(0, 1'b0, 1'b0, 0, 1'b1);
    @(negedge clk);
    check("b2b_restart_valid", 32'(o_tx_valid), 32'd1);
    i_start = 1'b0;
    drain(2, 1'b0, 1'b0, 0, 1'b0);

    random_regs();
    kick();
    drain(2, 1'b0, 1'b0, 60, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
